scan_chain_ctrl: RTL and testbench

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

---
 rtl/scan_chain_ctrl.sv | 130 +++++++++++++
 tb/tb_scan_chain_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
// scan_chain_ctrl : load / capture / unload sequencer for one serial scan chain
// Revision 1.0
// ============================================================================
`default_nettype none

module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rstBar,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 chain_so,
  output logic                 scan_en,
  output logic                 capture_en,
  output logic                 chain_si,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SHIFT_IN  = 3'd1,
    S_CAPTURE   = 3'd2,
    S_SHIFT_OUT = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] unload_sr_q, unload_sr_d;
  logic [CHAIN_LEN-1:0] unload_q, unload_d;

  always_ff @(posedge clk or negedge rstBar) begin
    if (!rstBar) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shadow_q    <= '0;
      unload_sr_q <= '0;
      unload_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      unload_sr_q <= unload_sr_d;
      unload_q    <= unload_d;
    end
  end

  // The shadow shifts right so bit 0 always holds the next bit to send, and
  // chain_so enters the unload register at the top so the first bit ends in bit 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    unload_sr_d = unload_sr_q;
    unload_d    = unload_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_SHIFT_IN;
          shadow_d = load_data;
          cnt_d    = '0;
        end
      end
      S_SHIFT_IN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          shadow_d = shadow_q >> 1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_CAPTURE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        state_d = abort ? S_IDLE : S_SHIFT_OUT;
        cnt_d   = '0;
      end
      S_SHIFT_OUT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          unload_sr_d = {chain_so, unload_sr_q[CHAIN_LEN-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            unload_d = unload_sr_d;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only, so reset clears them without a clock.
  always_comb begin
    scan_en     = (state_q == S_SHIFT_IN) || (state_q == S_SHIFT_OUT);
    capture_en  = (state_q == S_CAPTURE);
    chain_si    = (state_q == S_SHIFT_IN) && shadow_q[0];
    busy        = (state_q == S_SHIFT_IN) || (state_q == S_CAPTURE) ||
                  (state_q == S_SHIFT_OUT);
    done        = (state_q == S_DONE);
    unload_data = unload_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
// ============================================================================
// tb_scan_chain_ctrl : bench for scan_chain_ctrl with behavioural scan chains
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rstBar = 1'b0;
  logic abort = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] load8 = '0, cap8 = '0, chain8, unload8;
  logic       so8, scan_en8, capture_en8, si8, busy8, done8;

  logic       start2 = 1'b0;
  logic [1:0] load2 = '0, cap2 = '0, chain2, unload2;
  logic       so2, scan_en2, capture_en2, si2, busy2, done2;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(8), .CNT_W(4)) dut8 (
    .clk(clk), .rstBar(rstBar), .start(start8), .abort(abort),
    .load_data(load8), .chain_so(so8), .scan_en(scan_en8),
    .capture_en(capture_en8), .chain_si(si8), .busy(busy8),
    .done(done8), .unload_data(unload8)
  );

  scan_chain_ctrl #(.CHAIN_LEN(2), .CNT_W(4)) dut2 (
    .clk(clk), .rstBar(rstBar), .start(start2), .abort(abort),
    .load_data(load2), .chain_so(so2), .scan_en(scan_en2),
    .capture_en(capture_en2), .chain_si(si2), .busy(busy2),
    .done(done2), .unload_data(unload2)
  );

  // First stage is the MSB, last stage (chain_so) is bit 0.
  always @(posedge clk or negedge rstBar) begin
    if (!rstBar) begin
      chain8 <= '0;
      chain2 <= '0;
    end else begin
      if (capture_en8) chain8 <= cap8;
      else if (scan_en8) chain8 <= {si8, chain8[7:1]};
      if (capture_en2) chain2 <= cap2;
      else if (scan_en2) chain2 <= {si2, chain2[1]};
    end
  end
  assign so8 = chain8[0];
  assign so2 = chain2[0];

  typedef struct {
    int         n;
    logic [7:0] load;
    logic [7:0] cap;
    logic [7:0] exp_unload;
  } vec_t;

  function automatic logic [4:0] get_outs(input int n);
    if (n == 8) return {scan_en8, si8, capture_en8, busy8, done8};
    return {scan_en2, si2, capture_en2, busy2, done2};
  endfunction

  function automatic logic [7:0] get_unload(input int n);
    if (n == 8) return unload8;
    return {6'b0, unload2};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int n, input logic v);
    if (n == 8) start8 = v;
    else start2 = v;
  endtask

  // One sequence on the chosen DUT; cycle c is sampled 1ns after the c-th edge
  // counting the accepting edge as edge 1. sa/sb: extra start pulses, ab: abort.
  task automatic run_seq(input int n, input logic [7:0] ld, input logic [7:0] cp,
                         input logic [7:0] exp_unl, input int sa, input int sb,
                         input int ab);
    logic [4:0] exp;
    logic [7:0] prev_unl;
    int dones;
    int last;
    last = 2 * n + 4;
    dones = 0;
    prev_unl = get_unload(n);
    if (n == 8) begin load8 = ld; cap8 = cp; end
    else begin load2 = ld[1:0]; cap2 = cp[1:0]; end
    if (ab == 0) sb_q.push_back(exp_unl);
    set_start(n, 1'b1);
    @(posedge clk); #1;
    set_start(n, 1'b0);
    for (int c = 1; c <= last; c++) begin
      if (ab != 0 && c > ab) begin
        exp = '0;
      end else begin
        exp[4] = (c >= 1 && c <= n) || (c >= n + 2 && c <= 2 * n + 1);
        exp[3] = (c >= 1 && c <= n) ? ld[c-1] : 1'b0;
        exp[2] = (c == n + 1);
        exp[1] = (c >= 1 && c <= 2 * n + 1);
        exp[0] = (c == 2 * n + 2);
      end
      check($sformatf("n%0d_cyc%0d_outs", n, c), {3'b0, get_outs(n)}, {3'b0, exp});
      if (get_outs(n) & 5'b00001) begin
        dones++;
        if (sb_q.size() == 0) begin
          check($sformatf("n%0d_cyc%0d_unexpected_done", n, c), 8'd1, 8'd0);
        end else begin
          check($sformatf("n%0d_unload", n), get_unload(n), sb_q.pop_front());
        end
      end
      set_start(n, (c == sa) || (c == sb));
      abort = (c == ab);
      @(posedge clk); #1;
    end
    set_start(n, 1'b0);
    abort = 1'b0;
    check($sformatf("n%0d_done_count", n), 8'(dones), (ab == 0) ? 8'd1 : 8'd0);
    if (ab != 0) check($sformatf("n%0d_unload_held", n), get_unload(n), prev_unl);
  endtask

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8, 8'hA5, 8'h3C, 8'h3C};
    vecs[1] = '{8, 8'hFF, 8'h00, 8'h00};
    vecs[2] = '{8, 8'h00, 8'hC3, 8'hC3};
    vecs[3] = '{2, 8'h02, 8'h01, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs8", {3'b0, get_outs(8)}, 8'h00);
    check("rst_unload8", unload8, 8'h00);
    check("rst_outs2", {3'b0, get_outs(2)}, 8'h00);
    rstBar = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      run_seq(vecs[i].n, vecs[i].load, vecs[i].cap, vecs[i].exp_unload, 0, 0, 0);

    // Restore 0x3C, then busy-start pulses, then abort in SHIFT_OUT.
    run_seq(8, 8'hA5, 8'h3C, 8'h3C, 5, 12, 0);
    run_seq(8, 8'h0F, 8'hF0, 8'hF0, 0, 0, 11);

    start8 = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", {7'b0, busy8}, 8'h00);
    run_seq(8, 8'h5A, 8'h81, 8'h81, 0, 0, 0);

    // Asynchronous reset part-way through cycle 14.
    load8 = 8'h33;
    cap8 = 8'hEE;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("pre_rst_busy", {7'b0, busy8}, 8'h01);
    #2;
    rstBar = 1'b0;
    #1;
    check("async_rst_outs8", {3'b0, get_outs(8)}, 8'h00);
    check("async_rst_unload8", unload8, 8'h00);
    @(posedge clk); #1;
    rstBar = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {3'b0, get_outs(8)}, 8'h00);
    run_seq(8, 8'h96, 8'h69, 8'h69, 0, 0, 0);

    check("scoreboard_empty", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
